rr_arb8: RTL and testbench



---
 rtl/rr_arb_pkg.sv | 11 +
 rtl/rr_arb8_if.sv | 33 +++
 rtl/rr_pick8.sv | 36 +++
 rtl/rr_arb8.sv | 105 ++++++++++
 tb/tb_rr_arb8.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// Shared constants, state type and helpers for the eight-way round-robin arbiter.
package rr_arb_pkg;
    localparam int NREQ = 8;
    localparam int IDW  = 3;

    typedef enum logic {IDLE, GRANT} state_t;

    function automatic logic [NREQ-1:0] id2onehot(input logic [IDW-1:0] id);
        return NREQ'(1) << id;
    endfunction
endpackage

// File: rtl/rr_arb8_if.sv
// Request/data bundle from the eight producers and the grant/beat channel to the consumer.
interface rr_arb8_if
    import rr_arb_pkg::*;
#(
    parameter int W = 8
);
    logic [NREQ-1:0] req;
    logic [W-1:0]    d0;
    logic [W-1:0]    d1;
    logic [W-1:0]    d2;
    logic [W-1:0]    d3;
    logic [W-1:0]    d4;
    logic [W-1:0]    d5;
    logic [W-1:0]    d6;
    logic [W-1:0]    d7;
    logic            out_ready;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_valid;
    logic [W-1:0]    y;

    // Environment side: producers plus the consumer's ready.
    modport master (
        output req, d0, d1, d2, d3, d4, d5, d6, d7, out_ready,
        input  gnt, gnt_id, gnt_valid, y
    );

    // Arbiter side.
    modport slave (
        input  req, d0, d1, d2, d3, d4, d5, d6, d7, out_ready,
        output gnt, gnt_id, gnt_valid, y
    );
endinterface

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first requester after i_last, wrapping, with i_last itself lowest.
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_last,
    output logic [IDW-1:0]  o_winner,
    output logic            o_any
);
    logic [IDW-1:0]  w_base;
    logic [NREQ-1:0] w_rot;
    logic [IDW-1:0]  w_off;

    assign w_base = i_last + IDW'(1);

    // Rotate so that bit 0 of w_rot is the highest-priority requester.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [IDW-1:0] w_idx;
            assign w_idx      = w_base + IDW'(gi);
            assign w_rot[gi]  = i_req[w_idx];
        end
    endgenerate

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDW'(k);
            end
        end
    end

    assign o_any    = |w_rot;
    assign o_winner = w_base + w_off;
endmodule

// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter with per-grant beat limit and downstream backpressure.
module rr_arb8
    import rr_arb_pkg::*;
#(
    parameter int W    = 8,
    parameter int HOLD = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    rr_arb8_if.slave bus
);
    localparam int CW = $clog2(HOLD + 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [IDW-1:0]  r_last;
    logic [IDW-1:0]  r_gnt_id;
    logic [NREQ-1:0] r_gnt;
    logic            r_gnt_valid;

    logic [IDW-1:0]  w_pick_last;
    logic [IDW-1:0]  w_winner;
    logic            w_any;
    logic            w_accept;
    logic            w_last_beat;
    logic            w_exit;
    logic [W-1:0]    w_d [NREQ];
    logic [W-1:0]    w_y;

    // On exit the pointer becomes the current grantee, so search from it directly.
    assign w_pick_last = (r_state == GRANT) ? r_gnt_id : r_last;

    rr_pick8 u_pick (
        .i_req    (bus.req),
        .i_last   (w_pick_last),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    assign w_accept    = r_gnt_valid & bus.out_ready;
    assign w_last_beat = w_accept && (r_cnt == CW'(HOLD - 1));
    assign w_exit      = (r_state == GRANT) && (!bus.req[r_gnt_id] || w_last_beat);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last      <= IDW'(NREQ - 1);
            r_gnt_id    <= '0;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state     <= GRANT;
                        r_gnt       <= id2onehot(w_winner);
                        r_gnt_id    <= w_winner;
                        r_gnt_valid <= 1'b1;
                        r_cnt       <= '0;
                    end
                end
                GRANT: begin
                    if (w_exit) begin
                        r_last <= r_gnt_id;
                        r_cnt  <= '0;
                        if (w_any) begin
                            r_gnt    <= id2onehot(w_winner);
                            r_gnt_id <= w_winner;
                        end else begin
                            r_state     <= IDLE;
                            r_gnt       <= '0;
                            r_gnt_id    <= '0;
                            r_gnt_valid <= 1'b0;
                        end
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_d[0] = bus.d0;
    assign w_d[1] = bus.d1;
    assign w_d[2] = bus.d2;
    assign w_d[3] = bus.d3;
    assign w_d[4] = bus.d4;
    assign w_d[5] = bus.d5;
    assign w_d[6] = bus.d6;
    assign w_d[7] = bus.d7;

    always_comb begin
        w_y = '0;
        if (r_gnt_valid) begin
            w_y = w_d[r_gnt_id];
        end
    end

    assign bus.y         = w_y;
    assign bus.gnt       = r_gnt;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.gnt_valid = r_gnt_valid;
endmodule

// File: tb/tb_rr_arb8.sv
// Bench for rr_arb8: hand-derived vector table, round-robin sweep, and random traffic against a reference model.
module tb_rr_arb8;
    import rr_arb_pkg::*;

    localparam int W    = 8;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_arb8_if #(.W(W)) bus ();

    rr_arb8 #(.W(W), .HOLD(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: who holds the channel, beats taken, most recent grantee.
    logic       m_valid;
    int         m_id;
    int         m_cnt;
    int         m_last;
    logic [W-1:0] dcur [8];

    typedef struct {
        logic       rn;
        logic [7:0] rq;
        logic       rd;
        logic [7:0] eg;
        logic [2:0] eid;
        logic       ev;
    } vec_t;

    vec_t tbl [30];

    function automatic int search(input int last, input logic [7:0] rq);
        for (int k = 1; k <= 8; k++) begin
            if (rq[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_d(input int i, input logic [W-1:0] v);
        dcur[i] = v;
        case (i)
            0: bus.d0 = v;
            1: bus.d1 = v;
            2: bus.d2 = v;
            3: bus.d3 = v;
            4: bus.d4 = v;
            5: bus.d5 = v;
            6: bus.d6 = v;
            default: bus.d7 = v;
        endcase
    endtask

    task automatic model_edge(input logic rn, input logic [7:0] rq, input logic rd);
        int w;
        int nc;
        if (!rn) begin
            m_valid = 1'b0; m_id = 0; m_cnt = 0; m_last = 7;
        end else if (!m_valid) begin
            w = search(m_last, rq);
            if (w >= 0) begin
                m_valid = 1'b1; m_id = w; m_cnt = 0;
            end
        end else begin
            nc = m_cnt + (rd ? 1 : 0);
            if (!rq[m_id] || (rd && nc == HOLD)) begin
                m_last = m_id;
                m_cnt  = 0;
                w = search(m_last, rq);
                if (w >= 0) m_id = w;
                else begin
                    m_valid = 1'b0; m_id = 0;
                end
            end else begin
                m_cnt = nc;
            end
        end
    endtask

    task automatic compare_model();
        check("model_gnt", bus.gnt, m_valid ? (32'd1 << m_id) : 32'd0);
        check("model_gnt_valid", bus.gnt_valid, m_valid);
        if (m_valid) check("model_gnt_id", bus.gnt_id, m_id);
        check("model_y", bus.y, m_valid ? dcur[m_id] : '0);
    endtask

    // Apply inputs for one cycle, advance the model across the edge, then sample.
    task automatic drive_cycle(input logic rn, input logic [7:0] rq, input logic rd);
        rst_n         = rn;
        bus.req       = rq;
        bus.out_ready = rd;
        @(posedge clk);
        model_edge(rn, rq, rd);
        #1;
        compare_model();
    endtask

    initial begin
        logic [7:0] rq;
        logic       rn;
        logic       rd;

        rst_n = 1'b0;
        bus.req = '0;
        bus.out_ready = 1'b0;
        m_valid = 1'b0; m_id = 0; m_cnt = 0; m_last = 7;
        for (int i = 0; i < 8; i++) set_d(i, 8'(8'hA5 + 8'h11 * i));

        //          rn    rq     rd    exp gnt exp id ev
        tbl[0]  = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[2]  = '{1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[3]  = '{1'b1, 8'h21, 1'b1, 8'h01, 3'd0, 1'b1};
        tbl[4]  = '{1'b1, 8'h20, 1'b1, 8'h20, 3'd5, 1'b1};
        tbl[5]  = '{1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[6]  = '{1'b1, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1};
        tbl[7]  = '{1'b1, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1};
        tbl[8]  = '{1'b1, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1};
        tbl[9]  = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[10] = '{1'b1, 8'h21, 1'b0, 8'h20, 3'd5, 1'b1};
        tbl[11] = '{1'b1, 8'h21, 1'b1, 8'h20, 3'd5, 1'b1};
        tbl[12] = '{1'b1, 8'h21, 1'b0, 8'h20, 3'd5, 1'b1};
        tbl[13] = '{1'b1, 8'h21, 1'b0, 8'h20, 3'd5, 1'b1};
        tbl[14] = '{1'b1, 8'h21, 1'b1, 8'h20, 3'd5, 1'b1};
        tbl[15] = '{1'b1, 8'h21, 1'b1, 8'h20, 3'd5, 1'b1};
        tbl[16] = '{1'b1, 8'h21, 1'b1, 8'h01, 3'd0, 1'b1};
        tbl[17] = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[18] = '{1'b1, 8'h40, 1'b1, 8'h40, 3'd6, 1'b1};
        tbl[19] = '{1'b1, 8'h40, 1'b1, 8'h40, 3'd6, 1'b1};
        tbl[20] = '{1'b1, 8'h40, 1'b1, 8'h40, 3'd6, 1'b1};
        tbl[21] = '{1'b1, 8'h40, 1'b1, 8'h40, 3'd6, 1'b1};
        tbl[22] = '{1'b1, 8'h40, 1'b1, 8'h40, 3'd6, 1'b1};
        tbl[23] = '{1'b1, 8'h40, 1'b1, 8'h40, 3'd6, 1'b1};
        tbl[24] = '{1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[25] = '{1'b1, 8'h04, 1'b1, 8'h04, 3'd2, 1'b1};
        tbl[26] = '{1'b1, 8'h04, 1'b1, 8'h04, 3'd2, 1'b1};
        tbl[27] = '{1'b0, 8'h04, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[28] = '{1'b1, 8'h05, 1'b1, 8'h01, 3'd0, 1'b1};
        tbl[29] = '{1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0};

        for (int i = 0; i < 30; i++) begin
            drive_cycle(tbl[i].rn, tbl[i].rq, tbl[i].rd);
            check($sformatf("vec%0d_gnt", i), bus.gnt, tbl[i].eg);
            check($sformatf("vec%0d_valid", i), bus.gnt_valid, tbl[i].ev);
            if (tbl[i].ev || !tbl[i].rn)
                check($sformatf("vec%0d_id", i), bus.gnt_id, tbl[i].eid);
            check($sformatf("vec%0d_y", i), bus.y, tbl[i].ev ? dcur[tbl[i].eid] : '0);
            $display("vec %0d: rst_n=%b req=%h rdy=%b -> gnt=%h id=%0d valid=%b y=%h",
                     i, tbl[i].rn, tbl[i].rq, tbl[i].rd, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.y);
        end

        // Full contention: each requester in turn, exactly HOLD cycles, no gaps.
        drive_cycle(1'b0, 8'hFF, 1'b1);
        for (int c = 0; c < 36; c++) begin
            drive_cycle(1'b1, 8'hFF, 1'b1);
            check($sformatf("rot%0d_id", c), bus.gnt_id, (c / HOLD) % 8);
            check($sformatf("rot%0d_valid", c), bus.gnt_valid, 1'b1);
            $display("rot %0d: gnt_id=%0d", c, bus.gnt_id);
        end

        // Random traffic with sticky requests, random backpressure and rare resets.
        drive_cycle(1'b0, 8'h00, 1'b0);
        rq = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
            end
            rn = ($urandom_range(0, 127) != 0);
            rd = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) set_d($urandom_range(0, 7), 8'($urandom));
            drive_cycle(rn, rq, rd);
            if (c % 100 == 0)
                $display("rnd %0d: req=%h rdy=%b -> gnt=%h valid=%b", c, rq, rd, bus.gnt, bus.gnt_valid);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
